// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. It sends one command byte to a PS/2 device
// through the full host request sequence:
//   - inhibit the clock line;
//   - assert the request-to-send start bit;
//   - shift out the 8 data bits (LSB first), odd parity and stop on
//     device-generated clock falls;
//   - check the device acknowledge bit.
// Both pins are driven open-drain through output enables (1 = pull low).
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   tx_valid     request to send tx_data
//   tx_data[7:0] command byte, sampled when tx_valid & tx_ready
//   tx_ready     high only while idle and able to accept a byte
//   tx_done      one-cycle pulse when the device acknowledged
//   tx_err       one-cycle pulse on missing ack (or watchdog timeout)
//   ps2_clk      PS/2 clock pin level (asynchronous)
//   ps2_data     PS/2 data pin level (asynchronous)
//   ps2_clk_oe   1 = drive clock pin low, 0 = release
//   ps2_data_oe  1 = drive data pin low, 0 = release
//
// Compile-time option:
//   PS2_HOST_TX_TIMEOUT_EN  adds a per-frame watchdog of TIMEOUT_CYCLES cycles
//                           counted from accept; on expiry both lines are
//                           released, tx_err pulses and the block returns to idle.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_SEND,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

   state_t           state_q, state_d;
   logic [2:0]       clk_sync_q, data_sync_q;
   logic [9:0]       frame_q, frame_d;      // {stop, parity, data[7:0]}
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             clk_fall;
   logic             data_s;

`ifdef PS2_HOST_TX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   // Oldest synchronizer stage high, next stage low: a device clock fall.
   assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
   assign data_s   = data_sync_q[2];

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bit_idx_d = bit_idx_q;
      inh_cnt_d = inh_cnt_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      tmo_d     = (state_q == S_IDLE) ? '0 : tmo_q + TMO_W'(1);
`endif

      case (state_q)
         S_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            bit_idx_d = 4'd0;
            // ready_q is low during a done/err pulse, so a held tx_valid is
            // only taken one cycle after the pulse.
            if (tx_valid && ready_q) begin
               frame_d   = {1'b1, ~^tx_data, tx_data};
               inh_cnt_d = '0;
               clk_oe_d  = 1'b1;
               state_d   = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            inh_cnt_d = inh_cnt_q + INH_W'(1);
            // Start bit goes low on the final inhibit cycle (one cycle overlap).
            if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 2)) begin
               data_oe_d = 1'b1;
            end
            if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
               clk_oe_d  = 1'b0;
               bit_idx_d = 4'd0;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            if (clk_fall) begin
               // Open drain: a 1 bit (including stop) means release.
               data_oe_d = ~frame_q[bit_idx_q];
               bit_idx_d = bit_idx_q + 4'd1;
               if (bit_idx_q == 4'd9) begin
                  state_d = S_ACK;
               end
            end
         end
         S_ACK: begin
            if (clk_fall) begin
               data_oe_d = 1'b0;
               if (!data_s) begin
                  state_d = S_WAIT_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (clk_sync_q[2] && data_s) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
      // Watchdog wins over every other transition, including WAIT_IDLE.
      if (state_q != S_IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         done_d    = 1'b0;
         err_d     = 1'b1;
         state_d   = S_IDLE;
      end
`endif

      ready_d = (state_d == S_IDLE) && !done_d && !err_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         clk_sync_q  <= 3'b111;
         data_sync_q <= 3'b111;
         frame_q     <= '0;
         bit_idx_q   <= 4'd0;
         inh_cnt_q   <= '0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
         data_sync_q <= {data_sync_q[1:0], ps2_data};
         frame_q     <= frame_d;
         bit_idx_q   <= bit_idx_d;
         inh_cnt_q   <= inh_cnt_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

`ifdef PS2_HOST_TX_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign tx_ready    = ready_q;
   assign tx_done     = done_q;
   assign tx_err      = err_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
   localparam int INH = 5000;
   localparam int H   = 12;   // device clock half period in system cycles
`ifdef PS2_HOST_TX_TIMEOUT_EN
   localparam int TMO = 8000;
`else
   localparam int TMO = 750000;
`endif

   localparam int M_IDLE = 0;
   localparam int M_INH  = 1;
   localparam int M_BUSY = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, tx_done, tx_err;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_pin, ps2_data_pin;

   // Open-drain wired-AND of host and device on each line.
   assign ps2_clk_pin  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_pin = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .ps2_clk    (ps2_clk_pin),
      .ps2_data   (ps2_data_pin),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         n_done = 0;
   int         n_err = 0;
   logic [7:0] acc_q[$];
   bit         pulse_ok = 1'b0;
   bit         exp_ack = 1'b0;
   int         m_state = M_IDLE;
   int         m_age = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Expected line samples: start, data LSB first, odd parity, stop.
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
      f[9]  = ($countones(b) % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   // Cycle-level model of the host-side outputs.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("rst_ready", tx_ready, 1);
            chk("rst_clk_oe", ps2_clk_oe, 0);
            chk("rst_data_oe", ps2_data_oe, 0);
            chk("rst_done", tx_done, 0);
            chk("rst_err", tx_err, 0);
            m_state = M_IDLE;
            m_age   = 0;
         end else begin
            chk("done_err_exclusive", tx_done & tx_err, 0);
            if (tx_done) n_done++;
            if (tx_err) n_err++;
            case (m_state)
               M_IDLE: begin
                  chk("idle_ready", tx_ready, 1);
                  chk("idle_clk_oe", ps2_clk_oe, 0);
                  chk("idle_data_oe", ps2_data_oe, 0);
                  chk("idle_done", tx_done, 0);
                  chk("idle_err", tx_err, 0);
                  if (tx_valid) begin
                     acc_q.push_back(tx_data);
                     m_state = M_INH;
                     m_age   = 0;
                  end
               end
               M_INH: begin
                  m_age++;
                  chk("inh_ready", tx_ready, 0);
                  chk("inh_clk_oe", ps2_clk_oe, 1);
                  chk("inh_data_oe", ps2_data_oe, (m_age == INH));
                  chk("inh_pulse", tx_done | tx_err, 0);
                  if (m_age == INH) m_state = M_BUSY;
               end
               default: begin
                  m_age++;
                  chk("busy_ready", tx_ready, 0);
                  chk("busy_clk_oe", ps2_clk_oe, 0);
`ifdef PS2_HOST_TX_TIMEOUT_EN
                  if (m_age == TMO) begin
                     chk("timeout_err", tx_err, 1);
                     chk("timeout_data_oe", ps2_data_oe, 0);
                     m_state = M_IDLE;
                  end else
`endif
                  if (tx_done | tx_err) begin
                     chk("pulse_expected", pulse_ok, 1);
                     chk("pulse_kind_done", tx_done, exp_ack);
                     chk("pulse_data_oe", ps2_data_oe, 0);
                     m_state = M_IDLE;
                  end
               end
            endcase
         end
      end
   end

   // Device side of one frame: wait out the inhibit, clock 10 bits, then the ack.
   task automatic dev_frame(input bit ack, output logic [10:0] bits, output int inh_len);
      int w;
      int d0, e0;
      bits    = '0;
      inh_len = 0;
      w = 0;
      while (ps2_clk_oe !== 1'b1 && w < 50) begin tick(); w++; end
      while (ps2_clk_oe === 1'b1 && inh_len < INH + 100) begin inh_len++; tick(); end
      chk("inhibit_released", ps2_clk_oe, 0);
      repeat (8) tick();
      bits[0] = ps2_data_pin;
      for (int i = 1; i <= 10; i++) begin
         dev_clk = 1'b0; repeat (H) tick();
         dev_clk = 1'b1; bits[i] = ps2_data_pin; repeat (H) tick();
      end
      dev_data = ack ? 1'b0 : 1'b1;
      repeat (4) tick();
      d0 = n_done;
      e0 = n_err;
      exp_ack  = ack;
      pulse_ok = 1'b1;
      dev_clk = 1'b0; repeat (H) tick();
      dev_clk = 1'b1; repeat (H) tick();
      dev_data = 1'b1;
      w = 0;
      while (n_done == d0 && n_err == e0 && w < 100) begin tick(); w++; end
      pulse_ok = 1'b0;
      chk("done_pulses", n_done - d0, ack);
      chk("err_pulses", n_err - e0, !ack);
   endtask

   task automatic run_frame(input bit ack, input bit check_len, output logic [10:0] bits);
      int len;
      logic [7:0] b;
      dev_frame(ack, bits, len);
      if (check_len) chk("inhibit_cycles", len, 5000);
      chk("model_queue", acc_q.size(), 1);
      if (acc_q.size() != 0) begin
         b = acc_q.pop_front();
         chk("frame_bits", bits, model_frame(b));
         $display("frame byte=%02h ack=%0d bits=%011b", b, ack, bits);
      end
   endtask

   task automatic request(input logic [7:0] b);
      tx_valid = 1'b1;
      tx_data  = b;
      tick();
      tx_valid = 1'b0;
   endtask

   initial begin
      logic [10:0] bits;
      logic [7:0]  rb;
      int w, d0, e0;

      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();

      // 0xF4 with ack, pinned against a hand-derived frame
      request(8'hF4);
      run_frame(1'b1, 1'b1, bits);
      chk("f4_literal", bits, 11'b10111101000);
      repeat (2) tick();
      chk("f4_ready_back", tx_ready, 1);

      // Parity corner bytes
      request(8'h00); run_frame(1'b1, 1'b1, bits); chk("parity_00", bits[9], 1);
      repeat (2) tick();
      request(8'hED); run_frame(1'b1, 1'b1, bits); chk("parity_ed", bits[9], 1);
      repeat (2) tick();
      request(8'h01); run_frame(1'b1, 1'b1, bits); chk("parity_01", bits[9], 0);
      repeat (2) tick();

      // Device keeps data high on the 11th fall
      request(8'h3C);
      run_frame(1'b0, 1'b1, bits);
      repeat (2) tick();
      chk("nack_ready", tx_ready, 1);
      chk("nack_clk_oe", ps2_clk_oe, 0);
      chk("nack_data_oe", ps2_data_oe, 0);

      // tx_valid held while busy, tx_data changes mid-frame
      tx_valid = 1'b1;
      tx_data  = 8'hF4;
      w = 0;
      while (tx_ready !== 1'b0 && w < 10) begin tick(); w++; end
      tx_data = 8'h55;
      run_frame(1'b1, 1'b0, bits);
      chk("busy_first_is_f4", bits, 11'b10111101000);
      w = 0;
      while (ps2_clk_oe !== 1'b1 && w < 10) begin tick(); w++; end
      tx_valid = 1'b0;
      run_frame(1'b1, 1'b0, bits);
      chk("busy_second_is_55", bits[8:1], 8'h55);
      repeat (2) tick();

      // Reset after the 5th device clock fall
      request(8'hA7);
      w = 0;
      while (ps2_clk_oe === 1'b1 && w < INH + 100) begin tick(); w++; end
      repeat (8) tick();
      for (int i = 0; i < 5; i++) begin
         dev_clk = 1'b0; repeat (H) tick();
         dev_clk = 1'b1; repeat (H) tick();
      end
      chk("mid_frame_data_oe", ps2_data_oe, 1);
      d0 = n_done;
      e0 = n_err;
      reset = 1'b1;
      #1;
      chk("reset_clk_oe_now", ps2_clk_oe, 0);
      chk("reset_data_oe_now", ps2_data_oe, 0);
      chk("reset_ready_now", tx_ready, 1);
      repeat (2) tick();
      reset = 1'b0;
      acc_q.delete();
      repeat (2) tick();
      chk("reset_no_pulse", (n_done - d0) + (n_err - e0), 0);
      request(8'h5A);
      run_frame(1'b1, 1'b1, bits);
      repeat (2) tick();

      // Randomized bytes and ack outcomes
      for (int r = 0; r < 2; r++) begin
         rb = 8'($urandom_range(0, 255));
         request(rb);
         run_frame(($urandom_range(0, 3) != 0), 1'b1, bits);
         repeat (2) tick();
      end

      // Silent device
      d0 = n_done;
      e0 = n_err;
      request(8'h99);
`ifdef PS2_HOST_TX_TIMEOUT_EN
      w = 0;
      while (n_err == e0 && w < TMO + 200) begin tick(); w++; end
      chk("silent_timeout_err", n_err - e0, 1);
      chk("silent_data_oe", ps2_data_oe, 0);
      chk("silent_no_done", n_done - d0, 0);
      repeat (2) tick();
      chk("silent_ready_back", tx_ready, 1);
`else
      repeat (6000) tick();
      chk("silent_stays_busy", tx_ready, 0);
      chk("silent_no_pulse", (n_done - d0) + (n_err - e0), 0);
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
`endif
      acc_q.delete();
      $display("silent device byte=99 done=%0d err=%0d", n_done - d0, n_err - e0);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
